dcache_wb_assoc: RTL and testbench
==================================

// Module: dcache_wb_assoc
// PURPOSE
//  Parametrised 2-way set-associative, write-back, write-allocate data cache between datapath and memory controller.
//  Successor to the fixed 8-set/2-word dcache: set count and block size are parameters, victim selection is true per-set LRU.
//  On halt, it writes back dirty lines only (clean lines skipped), then stores the hit count to memory and raises flushed.
// PARAMETERS
//  SETS        8        number of sets; power of 2, >=2
//  BLK_WORDS   2        32-bit words per block; power of 2, >=2
//  HITCNT_ADDR 32'h3100 word address receiving the hit count after flush
// PORTS
//  CLK        in   1   clock, rising edge
//  nRST       in   1   asynchronous active-low reset
//  dmemREN    in   1   datapath read request
//  dmemWEN    in   1   datapath write request (never both with REN)
//  dmemaddr   in   32  datapath word address ([1:0] ignored)
//  dmemstore  in   32  datapath write data
//  halt       in   1   flush request; level, sampled in IDLE
//  dhit       out  1   request serviced this cycle
//  dmemload   out  32  read data; valid while dhit && dmemREN
//  flushed    out  1   flush and count write complete; sticky
//  dREN       out  1   memory read strobe
//  dWEN       out  1   memory write strobe
//  daddr      out  32  memory word address
//  dstore     out  32  memory write data
//  dload      in   32  memory read data; valid when dwait low
//  dwait      in   1   memory busy; a word transfer completes in a cycle with strobe high and dwait low
// BEHAVIOUR
//  Address fields: OFF=log2(BLK_WORDS), IDX=log2(SETS); word offset=addr[2+:OFF], index=addr[2+OFF+:IDX], tag=remaining upper bits.
//  Line contents: valid, dirty, tag, BLK_WORDS words. One LRU bit per set names the victim way.
//  Reset: all lines invalid and clean; LRU=0; hit counter=0; state IDLE.
//  Reset outputs: all 0, except dmemload, which is don't-care.
//  A reset mid-transfer aborts with no partial-line update retained as valid.
//  Hit: (REN|WEN) && valid && tag match in either way. dhit is combinational, so a hit costs zero wait states.
//  On a hit: LRU[idx] <= ~hitway.
//  On a write hit: update the word and set dirty.
//  On a hit: hit counter += 1 (wraps at 2^32).
//  FSM:
//   IDLE:     halt -> FLUSH_SCAN (halt has priority over a pending request).
//             Otherwise, a miss with a dirty victim -> WB.
//             Otherwise, a miss -> FETCH.
//             No request -> IDLE.
//   WB:       dWEN=1; daddr={victim tag, idx, wordcnt, 2'b00}; dstore=victim word[wordcnt].
//             wordcnt advances on !dwait. After word BLK_WORDS-1 -> FETCH.
//   FETCH:    dREN=1; daddr={req tag, idx, wordcnt, 2'b00}.
//             On !dwait, dload is written into victim word[wordcnt].
//             After the last word: victim.valid=1, dirty=0, tag=req tag -> IDLE.
//             The request then hits in IDLE on the next cycle. LRU is updated by that hit, not by the fill.
//   FLUSH_SCAN: iterates (set,way) from set 0 way 0 to set SETS-1 way 1, one pair per cycle.
//             Dirty and valid line -> FLUSH_WB. Otherwise skip to the next pair.
//             After the last pair -> CNT_WR.
//   FLUSH_WB: same word sequencing as WB, using the line's own tag.
//             Clears dirty when done, then returns to FLUSH_SCAN at the next pair.
//   CNT_WR:   dWEN=1, daddr=HITCNT_ADDR, dstore=hit counter. On !dwait -> DONE.
//   DONE:     flushed=1, all strobes 0. Stays until reset; requests are ignored.
//  dhit=0 in every state except IDLE.
//  A single word counter (OFF bits) wraps to 0 at the end of each line.
//  dstore and daddr are held stable while dwait is high.
//  Victim: the invalid way if exactly one way is invalid (way 0 if both are invalid); else LRU[idx].
//  The cache performs no partial stalls: datapath request inputs are held by the datapath until dhit.
// TESTING
//  Cold read 0x100 (SETS=8,BLK=2), memory returns A,B, dwait 2 cycles/word -> 2 dREN words 0x100,0x104; then dhit, dmemload=A.
//  Write 0x104=D5 after that fill -> dhit same cycle, no memory traffic; line dirty; a later read of 0x104 returns D5.
//  Fill both ways of set 0 (0x000,0x040), touch 0x000, miss 0x080 -> victim is the 0x040 way; if dirty, WB 0x040,0x044 precedes FETCH 0x080.
//  Halt with 3 dirty lines among 16 -> exactly 6 dWEN words, then a write of the hit count to 0x3100; flushed=1 and sticky.
//  nRST low during FETCH word 1 -> outputs 0; after release a read of the same address misses and refetches the whole line.
//  SETS=16,BLK_WORDS=4: read 0x1F0 -> FETCH of 0x1F0..0x1FC, word order 0..3; index=15 decoded correctly.

Source files
------------

// File: rtl/dcache_wb_assoc.sv
// dcache_wb_assoc: 2-way set-associative write-back write-allocate data cache with per-set LRU and halt flush
module dcache_wb_assoc #(
  parameter int SETS = 8,
  parameter int BLK_WORDS = 2,
  parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);
  localparam int OFF = $clog2(BLK_WORDS);
  localparam int IDX = $clog2(SETS);
  localparam int TAGW = 30 - OFF - IDX;
  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH_SCAN, FLUSH_WB, CNT_WR, DONE} state_t;
  state_t state, nxt;
  logic [31:0] data [2][SETS][BLK_WORDS];
  logic [TAGW-1:0] tags [2][SETS];
  logic [1:0][SETS-1:0] valid, dirty;
  logic [SETS-1:0] lru;
  logic [31:0] hitcnt;
  logic [OFF-1:0] wcnt, off;
  logic [IDX:0] pair;
  logic [IDX-1:0] idx, cs;
  logic [TAGW-1:0] tag;
  logic cw, hit0, hit1, hitway, victim, xfer, last_word, last_pair, scan_dirty, line_done, unused_ok;
  assign off = dmemaddr[2 +: OFF];
  assign idx = dmemaddr[2+OFF +: IDX];
  assign tag = dmemaddr[31 -: TAGW];
  assign unused_ok = ^dmemaddr[1:0];
  // pair holds {set, way}: the victim slot during a miss, the scan position during a flush
  assign cs = pair[IDX:1];
  assign cw = pair[0];
  assign hit0 = valid[0][idx] && tags[0][idx] == tag;
  assign hit1 = valid[1][idx] && tags[1][idx] == tag;
  assign hitway = hit1;
  assign dhit = state == IDLE && !halt && (dmemREN || dmemWEN) && (hit0 || hit1);
  assign dmemload = data[hitway][idx][off];
  assign victim = !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];
  assign xfer = !dwait;
  assign last_word = &wcnt;
  assign last_pair = &pair;
  assign scan_dirty = valid[cw][cs] && dirty[cw][cs];
  assign line_done = xfer && last_word;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    dREN = 1'b0;
    dWEN = 1'b0;
    daddr = '0;
    dstore = '0;
    flushed = 1'b0;
    case (state)
      IDLE: nxt = halt ? FLUSH_SCAN
                : (dmemREN || dmemWEN) && !(hit0 || hit1) ? (valid[victim][idx] && dirty[victim][idx] ? WB : FETCH)
                : IDLE;
      WB, FLUSH_WB: begin
        dWEN = 1'b1;
        daddr = {tags[cw][cs], cs, wcnt, 2'b00};
        dstore = data[cw][cs][wcnt];
        if (line_done) nxt = state == WB ? FETCH : last_pair ? CNT_WR : FLUSH_SCAN;
      end
      FETCH: begin
        dREN = 1'b1;
        daddr = {tag, cs, wcnt, 2'b00};
        if (line_done) nxt = IDLE;
      end
      FLUSH_SCAN: nxt = scan_dirty ? FLUSH_WB : last_pair ? CNT_WR : FLUSH_SCAN;
      CNT_WR: begin
        dWEN = 1'b1;
        daddr = HITCNT_ADDR;
        dstore = hitcnt;
        if (xfer) nxt = DONE;
      end
      DONE: flushed = 1'b1;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      valid <= '0;
      dirty <= '0;
      lru <= '0;
      hitcnt <= '0;
      wcnt <= '0;
      pair <= '0;
    end else begin
      if (dhit) begin
        lru[idx] <= ~hitway;
        hitcnt <= hitcnt + 32'd1;
        if (dmemWEN) dirty[hitway][idx] <= 1'b1;
      end
      if ((state == WB || state == FETCH || state == FLUSH_WB) && xfer) wcnt <= wcnt + 1'b1;
      if (state == IDLE) pair <= halt ? '0 : {idx, victim};
      if ((state == FLUSH_SCAN && !scan_dirty) || (state == FLUSH_WB && line_done)) pair <= pair + 1'b1;
      if (state == FLUSH_WB && line_done) dirty[cw][cs] <= 1'b0;
      if (state == FETCH && line_done) begin
        valid[cw][cs] <= 1'b1;
        dirty[cw][cs] <= 1'b0;
      end
    end
  // line storage carries no reset: valid bits alone decide what is usable
  always_ff @(posedge CLK) begin
    if (dhit && dmemWEN) data[hitway][idx][off] <= dmemstore;
    if (state == FETCH && xfer) data[cw][cs][wcnt] <= dload;
    if (state == FETCH && line_done) tags[cw][cs] <= tag;
  end
endmodule

// File: tb/tb_dcache_wb_assoc.sv
// tb_dcache_wb_assoc: checks both an 8x2 and a 16x4 cache against a block-level LRU model and a latency memory
module tb_dcache_wb_assoc;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;
  logic ren = 1'b0, wen = 1'b0, halt = 1'b0;
  logic [31:0] addr = '0, store = '0;
  int sel = 0;
  logic [31:0] dload = '0;
  logic dwait = 1'b1;
  logic dhit0, dhit1, fl0, fl1, dren0, dren1, dwen0, dwen1;
  logic [31:0] ld0, ld1, da0, da1, ds0, ds1;
  logic c_dhit, c_fl, c_dren, c_dwen;
  logic [31:0] c_ld, c_da, c_ds;
  int errors = 0, checks = 0;

  dcache_wb_assoc u0 (.CLK(CLK), .nRST(nRST), .dmemREN(ren && sel == 0), .dmemWEN(wen && sel == 0),
    .dmemaddr(addr), .dmemstore(store), .halt(halt && sel == 0), .dhit(dhit0), .dmemload(ld0),
    .flushed(fl0), .dREN(dren0), .dWEN(dwen0), .daddr(da0), .dstore(ds0), .dload(dload), .dwait(dwait));
  dcache_wb_assoc #(.SETS(16), .BLK_WORDS(4)) u1 (.CLK(CLK), .nRST(nRST), .dmemREN(ren && sel == 1),
    .dmemWEN(wen && sel == 1), .dmemaddr(addr), .dmemstore(store), .halt(halt && sel == 1), .dhit(dhit1),
    .dmemload(ld1), .flushed(fl1), .dREN(dren1), .dWEN(dwen1), .daddr(da1), .dstore(ds1), .dload(dload),
    .dwait(dwait));

  assign c_dhit = sel != 0 ? dhit1 : dhit0;
  assign c_fl = sel != 0 ? fl1 : fl0;
  assign c_dren = sel != 0 ? dren1 : dren0;
  assign c_dwen = sel != 0 ? dwen1 : dwen0;
  assign c_ld = sel != 0 ? ld1 : ld0;
  assign c_da = sel != 0 ? da1 : da0;
  assign c_ds = sel != 0 ? ds1 : ds0;

  typedef struct {bit we; logic [31:0] a; logic [31:0] d;} xfer_t;
  xfer_t xlog[$];
  xfer_t exp_q[$];
  logic [31:0] mem [int unsigned];
  int cnt = 0, lat = 1;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000 ^ (a >> 3);
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  // memory: each word transfer needs lat busy cycles before it completes
  always @(posedge CLK or negedge nRST)
    if (!nRST) cnt = 0;
    else if (c_dren || c_dwen) begin
      if (!dwait) begin
        xlog.push_back('{c_dwen, c_da, c_dwen ? c_ds : dload});
        if (c_dwen) mem[c_da] = c_ds;
        cnt = 0;
      end else cnt++;
    end else cnt = 0;
  always @(negedge CLK) begin
    dwait = !((c_dren || c_dwen) && cnt >= lat);
    dload = mem_rd(c_da);
  end

  // reference model: resident blocks with last-use stamps, architectural memory image
  int unsigned m_words, m_sets, now_t;
  int unsigned use_t [int unsigned];
  bit dty [int unsigned];
  logic [31:0] arch [int unsigned];
  logic [31:0] nhits;

  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    return arch.exists(a) ? arch[a] : init_val(a);
  endfunction

  task automatic model_access(input bit we, input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
    int unsigned b, s, n, lru_b, lru_t, bb;
    logic [31:0] wa;
    xfer_t e;
    wa = {a[31:2], 2'b00};
    bb = 4 * m_words;
    b = wa / bb;
    s = b % m_sets;
    exp_q.delete();
    if (!use_t.exists(b)) begin
      n = 0;
      lru_t = 32'hFFFF_FFFF;
      lru_b = 0;
      foreach (use_t[k])
        if (k % m_sets == s) begin
          n++;
          if (use_t[k] < lru_t) begin
            lru_t = use_t[k];
            lru_b = k;
          end
        end
      if (n == 2) begin
        if (dty[lru_b])
          for (int w = 0; w < int'(m_words); w++) begin
            e.we = 1'b1;
            e.a = lru_b * bb + 4 * w;
            e.d = arch_rd(e.a);
            exp_q.push_back(e);
          end
        use_t.delete(lru_b);
        dty.delete(lru_b);
      end
      for (int w = 0; w < int'(m_words); w++) begin
        e.we = 1'b0;
        e.a = b * bb + 4 * w;
        e.d = '0;
        exp_q.push_back(e);
      end
      dty[b] = 1'b0;
    end
    now_t++;
    use_t[b] = now_t;
    if (we) begin
      dty[b] = 1'b1;
      arch[wa] = d;
    end
    rd = arch_rd(wa);
    nhits++;
  endtask

  task automatic reset_all(input int s);
    sel = s;
    ren = 1'b0;
    wen = 1'b0;
    halt = 1'b0;
    nRST = 1'b0;
    m_words = s != 0 ? 4 : 2;
    m_sets = s != 0 ? 16 : 8;
    use_t.delete();
    dty.delete();
    arch.delete();
    mem.delete();
    now_t = 0;
    nhits = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d, input string nm, output int cyc);
    logic [31:0] erd;
    int base;
    model_access(we, a, d, erd);
    base = xlog.size();
    ren = !we;
    wen = we;
    addr = a;
    store = d;
    #1;
    cyc = 0;
    while (!c_dhit && cyc < 4000) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    checks++;
    if (!c_dhit) begin
      errors++;
      $display("FAIL %s dhit: got 0 expected 1 (timeout at %h)", nm, a);
    end
    if (!we) begin
      checks++;
      if (c_ld !== erd) begin
        errors++;
        $display("FAIL %s dmemload @%h: got %h expected %h", nm, a, c_ld, erd);
      end
    end
    @(posedge CLK);
    #1;
    ren = 1'b0;
    wen = 1'b0;
    checks++;
    if (xlog.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL %s traffic count @%h: got %0d expected %0d", nm, a, xlog.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < xlog.size(); i++) begin
      checks++;
      if (xlog[base+i].we !== exp_q[i].we || xlog[base+i].a !== exp_q[i].a || (exp_q[i].we && xlog[base+i].d !== exp_q[i].d)) begin
        errors++;
        $display("FAIL %s traffic[%0d]: got we=%0b a=%h d=%h expected we=%0b a=%h d=%h", nm, i,
          xlog[base+i].we, xlog[base+i].a, xlog[base+i].d, exp_q[i].we, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic test_reset;
    sel = 0;
    nRST = 1'b0;
    #1;
    checks++;
    if ({dhit0, fl0, dren0, dwen0} !== 4'b0 || da0 !== '0 || ds0 !== '0) begin
      errors++;
      $display("FAIL reset u0: got dhit=%b fl=%b ren=%b wen=%b a=%h d=%h expected all 0", dhit0, fl0, dren0, dwen0, da0, ds0);
    end
    checks++;
    if ({dhit1, fl1, dren1, dwen1} !== 4'b0 || da1 !== '0 || ds1 !== '0) begin
      errors++;
      $display("FAIL reset u1: got dhit=%b fl=%b ren=%b wen=%b a=%h d=%h expected all 0", dhit1, fl1, dren1, dwen1, da1, ds1);
    end
    reset_all(0);
    addr = 32'h100;
    ren = 1'b1;
    #1;
    checks++;
    if (c_dhit !== 1'b0) begin
      errors++;
      $display("FAIL reset cold dhit: got %b expected 0", c_dhit);
    end
    ren = 1'b0;
  endtask

  task automatic test_cold_read_write_hit;
    int cyc;
    reset_all(0);
    lat = 2;
    access(1'b0, 32'h100, '0, "cold_read", cyc);
    checks++;
    if (cyc != 7) begin
      errors++;
      $display("FAIL cold_read latency: got %0d expected 7", cyc);
    end
    access(1'b1, 32'h104, 32'hD5, "write_hit", cyc);
    checks++;
    if (cyc != 0) begin
      errors++;
      $display("FAIL write_hit latency: got %0d expected 0", cyc);
    end
    access(1'b0, 32'h104, '0, "read_back", cyc);
    checks++;
    if (arch_rd(32'h104) !== 32'hD5) begin
      errors++;
      $display("FAIL read_back model: got %h expected d5", arch_rd(32'h104));
    end
  endtask

  task automatic test_lru;
    int cyc;
    reset_all(0);
    lat = 1;
    access(1'b0, 32'h000, '0, "lru_fill0", cyc);
    access(1'b0, 32'h040, '0, "lru_fill1", cyc);
    access(1'b1, 32'h044, 32'hCAFE_0044, "lru_dirty", cyc);
    access(1'b0, 32'h000, '0, "lru_touch", cyc);
    access(1'b0, 32'h080, '0, "lru_evict", cyc);
    checks++;
    if (xlog.size() < 4 || xlog[xlog.size()-4].a !== 32'h40 || xlog[xlog.size()-4].we !== 1'b1) begin
      errors++;
      $display("FAIL lru_victim first word: got a=%h expected a=00000040 we=1", xlog[xlog.size()-4].a);
    end
  endtask

  task automatic test_random(input int s, input int n);
    int cyc;
    logic [31:0] a;
    reset_all(s);
    for (int i = 0; i < n; i++) begin
      lat = $urandom_range(0, 3);
      a = $urandom_range(0, 3) * m_sets * m_words * 4 + $urandom_range(0, m_sets - 1) * m_words * 4
        + $urandom_range(0, m_words - 1) * 4 + $urandom_range(0, 3);
      access(1'($urandom_range(0, 1)), a, $urandom, "random", cyc);
    end
  endtask

  task automatic test_reset_mid;
    int base, cyc;
    reset_all(0);
    lat = 2;
    base = xlog.size();
    addr = 32'h200;
    ren = 1'b1;
    cyc = 0;
    while (xlog.size() < base + 1 && cyc < 100) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    checks++;
    if (!c_dren) begin
      errors++;
      $display("FAIL reset_mid in_fetch: got dREN=%b expected 1", c_dren);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if ({c_dhit, c_fl, c_dren, c_dwen} !== 4'b0 || c_da !== '0 || c_ds !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: got ren=%b wen=%b a=%h expected 0", c_dren, c_dwen, c_da);
    end
    ren = 1'b0;
    use_t.delete();
    dty.delete();
    nhits = '0;
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK);
    #1;
    access(1'b0, 32'h200, '0, "reset_mid_refetch", cyc);
  endtask

  task automatic test_flush;
    int cyc, base, n, prev_set, nwb;
    int unsigned blk;
    bit seen [int unsigned];
    reset_all(0);
    lat = 1;
    for (int s = 0; s < 8; s++)
      for (int t = 0; t < 2; t++) access(1'b0, 32'(t * 64 + s * 8), '0, "flush_fill", cyc);
    access(1'b1, 32'h00C, 32'h1111_000C, "flush_dirty", cyc);
    access(1'b1, 32'h060, 32'h2222_0060, "flush_dirty", cyc);
    access(1'b1, 32'h07C, 32'h3333_007C, "flush_dirty", cyc);
    base = xlog.size();
    halt = 1'b1;
    cyc = 0;
    while (!c_fl && cyc < 2000) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    checks++;
    if (!c_fl) begin
      errors++;
      $display("FAIL flush flushed: got 0 expected 1");
    end
    n = xlog.size() - base;
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL flush traffic count: got %0d expected 7", n);
    end
    prev_set = 0;
    nwb = 0;
    for (int i = 0; i < n - 1; i++) begin
      blk = xlog[base+i].a / (4 * m_words);
      checks++;
      if (!xlog[base+i].we || !dty.exists(blk) || !dty[blk] || xlog[base+i].d !== arch_rd(xlog[base+i].a)
          || int'(blk % m_sets) < prev_set || seen.exists(xlog[base+i].a)) begin
        errors++;
        $display("FAIL flush wb[%0d]: got we=%0b a=%h d=%h expected dirty-line word d=%h", i,
          xlog[base+i].we, xlog[base+i].a, xlog[base+i].d, arch_rd(xlog[base+i].a));
      end
      nwb += xlog[base+i].we ? 1 : 0;
      seen[xlog[base+i].a] = 1'b1;
      prev_set = blk % m_sets;
    end
    checks++;
    if (nwb != 6) begin
      errors++;
      $display("FAIL flush wb words: got %0d expected 6", nwb);
    end
    checks++;
    if (n < 1 || !xlog[base+n-1].we || xlog[base+n-1].a !== 32'h3100 || xlog[base+n-1].d !== nhits) begin
      errors++;
      $display("FAIL flush count write: got a=%h d=%h expected a=00003100 d=%h", xlog[base+n-1].a, xlog[base+n-1].d, nhits);
    end
    halt = 1'b0;
    ren = 1'b1;
    addr = 32'h000;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      checks++;
      if ({c_fl, c_dhit, c_dren, c_dwen} !== 4'b1000) begin
        errors++;
        $display("FAIL flush sticky: got fl=%b dhit=%b ren=%b wen=%b expected 1000", c_fl, c_dhit, c_dren, c_dwen);
      end
    end
    ren = 1'b0;
  endtask

  task automatic test_param;
    int cyc, base;
    reset_all(1);
    lat = 1;
    base = xlog.size();
    access(1'b0, 32'h1F0, '0, "p_cold", cyc);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (base + i >= xlog.size() || xlog[base+i].a !== 32'(32'h1F0 + 4 * i) || xlog[base+i].we) begin
        errors++;
        $display("FAIL p_order[%0d]: got a=%h expected %h", i, xlog[base+i].a, 32'(32'h1F0 + 4 * i));
      end
    end
    access(1'b0, 32'h1FC, '0, "p_hit", cyc);
    checks++;
    if (cyc != 0) begin
      errors++;
      $display("FAIL p_hit latency: got %0d expected 0", cyc);
    end
    access(1'b1, 32'h1F8, 32'hBEEF_01F8, "p_write", cyc);
    access(1'b0, 32'h5F0, '0, "p_way1", cyc);
    access(1'b0, 32'hDF0, '0, "p_evict_dirty", cyc);
    access(1'b0, 32'h1F8, '0, "p_refetch", cyc);
  endtask

  initial begin
    test_reset();
    test_cold_read_write_hit();
    test_lru();
    test_random(0, 250);
    test_reset_mid();
    test_flush();
    test_param();
    test_random(1, 150);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
